jtkcpu_stack_seq: RTL and testbench



---
 rtl/jtkcpu_stack_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_jtkcpu_stack_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_stack_seq.sv
// jtkcpu_stack_seq: walks a register mask one byte per cen, pushing to or pulling from the stack bus.
// Optional stack guard (ovf flag) is compiled in by defining JTKCPU_STACK_GUARD_EN.
module jtkcpu_stack_seq #(
  parameter int unsigned     NREG  = 8,
  parameter int unsigned     AW    = 16,
  parameter logic [NREG-1:0] WIDE  = 8'hF0,
  parameter logic [AW-1:0]   LIMIT = {AW{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               start,
  input  logic               pul,
  input  logic [NREG-1:0]    sel,
  input  logic [AW-1:0]      sp_in,
  input  logic [NREG*16-1:0] regs,
  input  logic [7:0]         mdin,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      addr,
  output logic [7:0]         dout,
  output logic               we,
  output logic               rd,
  output logic [NREG-1:0]    up_sel,
  output logic               up_hi,
  output logic [7:0]         up_data,
  output logic [AW-1:0]      sp_out,
  output logic               ovf
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t          state, state_d;
  logic            pul_q, pul_d;
  logic [NREG-1:0] mask_q, mask_d;
  logic [AW-1:0]   sp_q, sp_d;
  logic            ph_q, ph_d;
  logic [NREG-1:0] pend_sel_q, pend_sel_d;
  logic            pend_hi_q, pend_hi_d;

  logic            busy_d, done_d, we_d, rd_d, up_hi_d;
  logic [AW-1:0]   addr_d, sp_out_d;
  logic [7:0]      dout_d, up_data_d;
  logic [NREG-1:0] up_sel_d;

  logic [NREG-1:0] pick_oh, mask_left;
  logic [15:0]     pick_val;
  logic            pick_wide, last_byte;
  logic [AW-1:0]   sp_dec, sp_inc;

`ifdef JTKCPU_STACK_GUARD_EN
  logic            ovf_q, ovf_d;
  assign ovf = ovf_q;
`else
  logic            unused_limit;
  assign ovf          = 1'b0;
  assign unused_limit = ^LIMIT;
`endif

  assign sp_dec = sp_q - AW'(1);
  assign sp_inc = sp_q + AW'(1);

  // Register selection: push serves the highest set bit, pull the lowest
  always_comb begin
    pick_oh   = '0;
    pick_val  = '0;
    pick_wide = 1'b0;
    if (pul_q) begin
      for (int i = int'(NREG) - 1; i >= 0; i--) begin
        if (mask_q[i]) begin
          pick_oh    = '0;
          pick_oh[i] = 1'b1;
          pick_val   = regs[i*16 +: 16];
          pick_wide  = WIDE[i];
        end
      end
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (mask_q[i]) begin
          pick_oh    = '0;
          pick_oh[i] = 1'b1;
          pick_val   = regs[i*16 +: 16];
          pick_wide  = WIDE[i];
        end
      end
    end
    last_byte = !pick_wide || ph_q;
    mask_left = mask_q & ~pick_oh;
  end

  // Next-state and registered-output logic; everything holds when cen is low
  always_comb begin
    state_d    = state;
    pul_d      = pul_q;
    mask_d     = mask_q;
    sp_d       = sp_q;
    ph_d       = ph_q;
    pend_sel_d = pend_sel_q;
    pend_hi_d  = pend_hi_q;
    busy_d     = busy;
    done_d     = done;
    we_d       = we;
    rd_d       = rd;
    addr_d     = addr;
    dout_d     = dout;
    up_sel_d   = up_sel;
    up_hi_d    = up_hi;
    up_data_d  = up_data;
    sp_out_d   = sp_out;
`ifdef JTKCPU_STACK_GUARD_EN
    ovf_d      = ovf_q;
`endif
    if (cen) begin
      done_d   = 1'b0;
      we_d     = 1'b0;
      rd_d     = 1'b0;
      // Byte read in the previous cen window lands on the register file now
      up_sel_d = rd ? pend_sel_q : '0;
      up_hi_d  = rd & pend_hi_q;
      if (rd) up_data_d = mdin;
      unique case (state)
        IDLE: begin
          if (start) begin
            pul_d   = pul;
            mask_d  = sel;
            sp_d    = sp_in;
            ph_d    = 1'b0;
            busy_d  = 1'b1;
`ifdef JTKCPU_STACK_GUARD_EN
            ovf_d   = 1'b0;
`endif
            state_d = (sel == '0) ? DONE : XFER;
          end
        end
        XFER: begin
          if (!pul_q) begin
            we_d   = 1'b1;
            addr_d = sp_dec;
            dout_d = ph_q ? pick_val[15:8] : pick_val[7:0];
            sp_d   = sp_dec;
`ifdef JTKCPU_STACK_GUARD_EN
            if (sp_q == '0 || sp_dec < LIMIT) ovf_d = 1'b1;
`endif
          end else begin
            rd_d       = 1'b1;
            addr_d     = sp_q;
            pend_sel_d = pick_oh;
            pend_hi_d  = pick_wide & !ph_q;
            sp_d       = sp_inc;
`ifdef JTKCPU_STACK_GUARD_EN
            if (sp_q == '1) ovf_d = 1'b1;
`endif
          end
          if (last_byte) begin
            mask_d = mask_left;
            ph_d   = 1'b0;
            if (mask_left == '0) state_d = DONE;
          end else begin
            ph_d = 1'b1;
          end
        end
        DONE: begin
          done_d   = 1'b1;
          busy_d   = 1'b0;
          sp_out_d = sp_q;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pul_q      <= 1'b0;
      mask_q     <= '0;
      sp_q       <= '0;
      ph_q       <= 1'b0;
      pend_sel_q <= '0;
      pend_hi_q  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      we         <= 1'b0;
      rd         <= 1'b0;
      addr       <= '0;
      dout       <= '0;
      up_sel     <= '0;
      up_hi      <= 1'b0;
      up_data    <= '0;
      sp_out     <= '0;
`ifdef JTKCPU_STACK_GUARD_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      pul_q      <= pul_d;
      mask_q     <= mask_d;
      sp_q       <= sp_d;
      ph_q       <= ph_d;
      pend_sel_q <= pend_sel_d;
      pend_hi_q  <= pend_hi_d;
      busy       <= busy_d;
      done       <= done_d;
      we         <= we_d;
      rd         <= rd_d;
      addr       <= addr_d;
      dout       <= dout_d;
      up_sel     <= up_sel_d;
      up_hi      <= up_hi_d;
      up_data    <= up_data_d;
      sp_out     <= sp_out_d;
`ifdef JTKCPU_STACK_GUARD_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_jtkcpu_stack_seq.sv
// tb_jtkcpu_stack_seq: vector table, hand-written corner sequences and randomized push/pull round trips.
// Expected bus traffic comes from a byte-level stack model that owns its own memory image.
module tb_jtkcpu_stack_seq;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 16;
  localparam logic [7:0]  WIDE = 8'hF0;

  logic         clk = 1'b0;
  logic         rst, cen, start, pul;
  logic [7:0]   sel;
  logic [15:0]  sp_in;
  logic [127:0] regs;
  logic [7:0]   mdin;
  logic         busy, done, we, rd, up_hi, ovf;
  logic [15:0]  addr, sp_out;
  logic [7:0]   dout, up_data, up_sel;

  always #5 clk = ~clk;

  jtkcpu_stack_seq #(.NREG(NREG), .AW(AW), .WIDE(WIDE)) dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .pul(pul), .sel(sel),
    .sp_in(sp_in), .regs(regs), .mdin(mdin), .busy(busy), .done(done),
    .addr(addr), .dout(dout), .we(we), .rd(rd), .up_sel(up_sel),
    .up_hi(up_hi), .up_data(up_data), .sp_out(sp_out), .ovf(ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic w; logic [15:0] a; logic [7:0] d; } bus_t;
  typedef struct { logic [7:0] s; logic h; logic [7:0] d; } ld_t;
  typedef struct { logic p; logic [7:0] s; logic [15:0] sp; int div; bit poke;
                   logic [15:0] e_sp; int e_bytes; } vec_t;

  logic [7:0]  mem     [65536];
  logic [7:0]  ref_mem [65536];
  logic [15:0] rv      [8];
  bus_t exp_bus[$], obs_bus[$];
  ld_t  exp_ld[$],  obs_ld[$];

  // Reference: byte list of a push/pull written straight from the stacking rules
  task automatic model(input logic p, input logic [7:0] s, input logic [15:0] sp,
                       output logic [15:0] sp_o, output logic ov);
    logic [15:0] cur;
    logic [7:0]  d;
    int          nb;
    cur = sp;
    ov  = 1'b0;
    exp_bus.delete();
    exp_ld.delete();
    if (!p) begin
      for (int i = 7; i >= 0; i--) begin
        if (s[i]) begin
          nb = WIDE[i] ? 2 : 1;
          for (int b = 0; b < nb; b++) begin
            d = (b == 0) ? rv[i][7:0] : rv[i][15:8];
            if (cur == 16'h0000) ov = 1'b1;
            cur = cur - 16'd1;
            exp_bus.push_back('{1'b1, cur, d});
            ref_mem[cur] = d;
          end
        end
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (s[i]) begin
          nb = WIDE[i] ? 2 : 1;
          for (int b = 0; b < nb; b++) begin
            exp_bus.push_back('{1'b0, cur, 8'h00});
            exp_ld.push_back('{8'(1 << i), (nb == 2 && b == 0), ref_mem[cur]});
            if (cur == 16'hFFFF) ov = 1'b1;
            cur = cur + 16'd1;
          end
        end
      end
    end
`ifndef JTKCPU_STACK_GUARD_EN
    ov = 1'b0;
`endif
    sp_o = cur;
  endtask

  task automatic load_regs();
    for (int i = 0; i < 8; i++) regs[i*16 +: 16] = rv[i];
  endtask

  // One complete sequence: start, run until done (bounded), compare against model
  task automatic run_seq(input logic p, input logic [7:0] s, input logic [15:0] sp,
                         input int div, input bit poke, input bit has_tab,
                         input logic [15:0] tab_sp, input int tab_bytes,
                         input string tag, output logic [15:0] sp_res);
    logic [15:0] m_sp, e_sp;
    logic        m_ov, was_cen, got_sp_busy, got_ovf;
    logic [15:0] got_sp;
    int          k, kd, e_bytes;
    bit          busy_ok, excl_ok;
    model(p, s, sp, m_sp, m_ov);
    e_sp    = has_tab ? tab_sp : m_sp;
    e_bytes = has_tab ? tab_bytes : exp_bus.size();
    sp_res  = m_sp;
    obs_bus.delete();
    obs_ld.delete();
    load_regs();
    @(negedge clk);
    start = 1'b1; pul = p; sel = s; sp_in = sp; cen = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy_at_accept"}, 32'(busy), 32'd1);
    k = 0; kd = -1; busy_ok = 1'b1; excl_ok = 1'b1;
    got_sp = '0; got_sp_busy = 1'b0; got_ovf = 1'b0;
    for (int cyc = 1; cyc < 400 && kd < 0; cyc++) begin
      @(negedge clk);
      cen = ((cyc % div) == 0);
      if (poke) begin
        start = cyc[0]; sel = ~s; sp_in = ~sp; pul = ~p;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      was_cen = cen;
      #1;
      if (we && rd) excl_ok = 1'b0;
      if (was_cen) begin
        k++;
        if (we) begin
          obs_bus.push_back('{1'b1, addr, dout});
          mem[addr] = dout;
        end
        if (rd) begin
          obs_bus.push_back('{1'b0, addr, 8'h00});
          mdin = mem[addr];
        end
        if (up_sel != 8'h00) obs_ld.push_back('{up_sel, up_hi, up_data});
        if (done) begin
          kd = k; got_sp = sp_out; got_sp_busy = busy; got_ovf = ovf;
        end else if (!busy) begin
          busy_ok = 1'b0;
        end
      end
    end
    check({tag, " latency"}, 32'(kd), 32'(e_bytes + 1));
    check({tag, " sp_out"}, 32'(got_sp), 32'(e_sp));
    check({tag, " busy_with_done"}, 32'(got_sp_busy), 32'd0);
    check({tag, " ovf"}, 32'(got_ovf), 32'(m_ov));
    check({tag, " busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, " we_rd_excl"}, 32'(excl_ok), 32'd1);
    check({tag, " bus_count"}, 32'(obs_bus.size()), 32'(e_bytes));
    for (int i = 0; i < obs_bus.size() && i < exp_bus.size(); i++)
      check($sformatf("%s bus%0d", tag, i), {7'd0, obs_bus[i].w, obs_bus[i].a, obs_bus[i].d},
            {7'd0, exp_bus[i].w, exp_bus[i].a, exp_bus[i].d});
    check({tag, " load_count"}, 32'(obs_ld.size()), 32'(exp_ld.size()));
    for (int i = 0; i < obs_ld.size() && i < exp_ld.size(); i++)
      check($sformatf("%s load%0d", tag, i), {15'd0, obs_ld[i].s, obs_ld[i].h, obs_ld[i].d},
            {15'd0, exp_ld[i].s, exp_ld[i].h, exp_ld[i].d});
    // done is a single-cen pulse and the bus is quiet afterwards
    @(negedge clk);
    start = 1'b0; cen = 1'b1;
    @(posedge clk); #1;
    check({tag, " done_pulse"}, {29'd0, done, busy, we | rd}, 32'd0);
    check({tag, " up_sel_idle"}, 32'(up_sel), 32'd0);
  endtask

  vec_t        vt[10];
  logic [15:0] spr, spr2;
  logic [7:0]  rs;
  int          rdiv;

  initial begin
    rst = 1'b1; cen = 1'b0; start = 1'b0; pul = 1'b0; sel = '0; sp_in = '0;
    regs = '0; mdin = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", {25'd0, busy, done, we, rd, up_hi, ovf, 1'b0}, 32'd0);
    check("reset_addr", 32'(addr), 32'd0);
    check("reset_data", {16'd0, dout, up_data}, 32'd0);
    check("reset_sel_sp", {8'd0, up_sel, sp_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) rv[i] = 16'($urandom);
    rv[7] = 16'hABCD;
    rv[0] = 16'h0012;

    vt[0] = '{1'b0, 8'h81, 16'h1000, 1, 1'b0, 16'h0FFD, 3};
    vt[1] = '{1'b1, 8'h81, 16'h0FFD, 1, 1'b0, 16'h1000, 3};
    vt[2] = '{1'b0, 8'h00, 16'h1234, 1, 1'b0, 16'h1234, 0};
    vt[3] = '{1'b1, 8'h00, 16'h4321, 2, 1'b0, 16'h4321, 0};
    vt[4] = '{1'b0, 8'h01, 16'h0000, 1, 1'b0, 16'hFFFF, 1};
    vt[5] = '{1'b1, 8'h01, 16'hFFFF, 1, 1'b0, 16'h0000, 1};
    vt[6] = '{1'b0, 8'hFF, 16'h2000, 3, 1'b1, 16'h1FF4, 12};
    vt[7] = '{1'b1, 8'hFF, 16'h1FF4, 3, 1'b1, 16'h2000, 12};
    vt[8] = '{1'b0, 8'h90, 16'h8000, 2, 1'b0, 16'h7FFC, 4};
    vt[9] = '{1'b1, 8'h0C, 16'h0100, 1, 1'b0, 16'h0102, 2};
    for (int v = 0; v < 10; v++)
      run_seq(vt[v].p, vt[v].s, vt[v].sp, vt[v].div, vt[v].poke, 1'b1,
              vt[v].e_sp, vt[v].e_bytes, $sformatf("vec%0d", v), spr);

    // Reset in the middle of a long push aborts immediately
    load_regs();
    @(negedge clk);
    start = 1'b1; pul = 1'b0; sel = 8'hFF; sp_in = 16'h3000; cen = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_we_before", 32'(we), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_after", {28'd0, busy, we, done, rd}, 32'd0);
    check("midrst_addr", 32'(addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_seq(1'b0, 8'h42, 16'h5000, 1, 1'b0, 1'b1, 16'h4FFD, 3, "post_rst", spr);

    // Randomized push followed by pull of the same mask from the resulting sp
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 8; i++) rv[i] = 16'($urandom);
      rs   = 8'($urandom);
      spr2 = (t % 5 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      rdiv = 1 + int'($urandom % 3);
      run_seq(1'b0, rs, spr2, rdiv, (t % 3 == 0), 1'b0, 16'h0, 0, $sformatf("rnd%0d_push", t), spr);
      run_seq(1'b1, rs, spr, rdiv, (t % 4 == 0), 1'b0, 16'h0, 0, $sformatf("rnd%0d_pull", t), spr2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
